// File: rtl/counter_timer_arbiter_if.sv
// Bundle of request/length inputs and grant/status outputs for the shared
// interval counter.
//   master : timing client side (drives req, len; observes status)
//   slave  : counter_timer_arbiter side
// Signals:
//   req     N_REQ        level request per requester
//   len     N_REQ*WIDTH  interval length per requester, slice i = len[i*WIDTH +: WIDTH]
//   grant   N_REQ        one-hot (or zero) current owner
//   busy    1            high whenever the arbiter is not idle
//   count   WIDTH        running count of the current interval
//   done    N_REQ        1-cycle pulse to the owner at interval end
//   aborted N_REQ        1-cycle pulse to the owner when its req dropped mid-run
interface counter_timer_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] len;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic [WIDTH-1:0]       count;
  logic [N_REQ-1:0]       done;
  logic [N_REQ-1:0]       aborted;

  modport master (
    output req, len,
    input  grant, busy, count, done, aborted
  );

  modport slave (
    input  req, len,
    output grant, busy, count, done, aborted
  );
endinterface

// File: rtl/counter_timer_arbiter.sv
// Shares one WIDTH-bit interval counter among N_REQ requesters.
// A round-robin arbiter picks an owner in IDLE, the FSM runs the counter for
// the owner's captured length, then pulses done (or aborted if the owner's
// request drops mid-run). All outputs are registered.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : counter_timer_arbiter_if.slave (req/len in; grant/busy/count/done/aborted out)
module counter_timer_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  counter_timer_arbiter_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [N_REQ-1:0]  grant_q;
  logic              busy_q;
  logic [WIDTH-1:0]  count_q;
  logic [WIDTH-1:0]  target_q;
  logic [N_REQ-1:0]  done_q;
  logic [N_REQ-1:0]  aborted_q;
  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   owner_q;

  logic              win_valid;
  logic [IdxW-1:0]   win_idx;
  logic [N_REQ-1:0]  win_onehot;
  logic [WIDTH-1:0]  win_len;

  // Round-robin pick: first set request searching upward from ptr_q + 1, wrapping.
  always_comb begin
    int cand;
    cand       = 0;
    win_valid  = 1'b0;
    win_idx    = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= int'(N_REQ)) cand = cand - int'(N_REQ);
      if (!win_valid && bus.req[cand]) begin
        win_valid = 1'b1;
        win_idx   = IdxW'(cand);
      end
    end
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
    win_len             = bus.len[int'(win_idx)*int'(WIDTH) +: WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      count_q   <= '0;
      target_q  <= '0;
      done_q    <= '0;
      aborted_q <= '0;
      ptr_q     <= IdxW'(N_REQ - 1);
      owner_q   <= '0;
    end else begin
      // done/aborted are single-cycle pulses unless set below.
      done_q    <= '0;
      aborted_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            grant_q  <= win_onehot;
            owner_q  <= win_idx;
            count_q  <= '0;
            target_q <= win_len;
            busy_q   <= 1'b1;
            // Zero-length interval: grant and done land in the same cycle.
            if (win_len == '0) begin
              state_q <= StDone;
              done_q  <= win_onehot;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          // Abort wins over the terminal-count transition.
          if (!bus.req[owner_q]) begin
            state_q   <= StIdle;
            aborted_q <= grant_q;
            grant_q   <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= owner_q;
          end else begin
            // Count advances on the terminal edge too, so DONE shows count == target.
            count_q <= count_q + CountOne;
            if (count_q == target_q - CountOne) begin
              state_q <= StDone;
              done_q  <= grant_q;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          grant_q <= '0;
          count_q <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= owner_q;
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          count_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.count   = count_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;

endmodule
